// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS subset core: one shared ALU and one valid/ready memory port
// sequenced through FETCH/DECODE/EXEC/MEM/WB, plus a store-mapped output register.
module mips_multicycle #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(16'hFFEC),
    parameter int                NREGS    = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       CPU_out,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_out
);
    localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, addr_reg;
    logic [31:0]       ir_reg, a_reg, b_reg, res_reg, cpu_out_reg;
    logic              illegal_reg;
    logic [31:0]       regs [NREGS];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt, wr_idx;
    logic [31:0] simm, zimm, rs_val, rt_val, alu_res, pc32;
    logic        is_r, is_j, is_beq, is_ori, is_lw, is_sw, is_halt, r_ok, legal;
    logic        out_hit, misaligned, rf_we;
    logic [ADDR_W-1:0] addr_calc, br_target, j_target, pc_plus4;

    assign op    = ir_reg[31:26];
    assign rs    = ir_reg[25:21];
    assign rt    = ir_reg[20:16];
    assign rd    = ir_reg[15:11];
    assign shamt = ir_reg[10:6];
    assign funct = ir_reg[5:0];
    assign simm  = {{16{ir_reg[15]}}, ir_reg[15:0]};
    assign zimm  = {16'h0, ir_reg[15:0]};

    assign is_halt = (ir_reg == 32'hFFFF_FFFF);
    assign is_r    = (op == OP_R);
    assign is_j    = (op == OP_J);
    assign is_beq  = (op == OP_BEQ);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign r_ok    = (funct == FN_SLL) || (funct == FN_ADD) || (funct == FN_SUB) ||
                     (funct == FN_AND) || (funct == FN_OR)  || (funct == FN_SLT);
    assign legal   = is_r ? r_ok : (is_j || is_beq || is_ori || is_lw || is_sw || op == OP_ADDI);

    // Branch/jump targets are formed from the already-incremented PC.
    assign pc32       = 32'(pc_reg);
    assign pc_plus4   = pc_reg + ADDR_W'(4);
    assign addr_calc  = ADDR_W'(a_reg + simm);
    assign br_target  = ADDR_W'(pc32 + {simm[29:0], 2'b00});
    assign j_target   = ADDR_W'({pc32[31:28], ir_reg[25:0], 2'b00});
    assign misaligned = (addr_calc[1:0] != 2'b00);
    assign out_hit    = is_sw && (addr_reg == OUT_ADDR);

    assign wr_idx = is_r ? rd : rt;
    assign rf_we  = (state_reg == S_WB) && (wr_idx != 5'd0) && (32'(wr_idx) < 32'(NREGS));

    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != 5'd0 && 32'(rs) < 32'(NREGS)) rs_val = regs[rs[RI_W-1:0]];
        if (rt != 5'd0 && 32'(rt) < 32'(NREGS)) rt_val = regs[rt[RI_W-1:0]];
    end

    always_comb begin
        alu_res = '0;
        if (is_r) begin
            case (funct)
                FN_ADD:  alu_res = a_reg + b_reg;
                FN_SUB:  alu_res = a_reg - b_reg;
                FN_AND:  alu_res = a_reg & b_reg;
                FN_OR:   alu_res = a_reg | b_reg;
                FN_SLT:  alu_res = {31'b0, $signed(a_reg) < $signed(b_reg)};
                FN_SLL:  alu_res = b_reg << shamt;
                default: alu_res = '0;
            endcase
        end else if (is_ori) begin
            alu_res = a_reg | zimm;
        end else begin
            alu_res = a_reg + simm;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (rf_we) begin
            regs[wr_idx[RI_W-1:0]] <= res_reg;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (is_halt || !legal) state_next = S_HALT;
                else if (is_j)         state_next = S_FETCH;
                else                   state_next = S_EXEC;
            end
            S_EXEC: begin
                if (is_beq)                state_next = S_FETCH;
                else if (is_lw || is_sw)   state_next = misaligned ? S_HALT : S_MEM;
                else                       state_next = S_WB;
            end
            S_MEM: begin
                if (out_hit)        state_next = S_FETCH;
                else if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state_next = S_FETCH;
            default: state_next = S_HALT;
        endcase
    end

    // Reset gates the request so a transfer never starts while Reset is held.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = pc_reg;
        mem_wdata = '0;
        if (!Reset) begin
            case (state_reg)
                S_FETCH: mem_req = 1'b1;
                S_MEM: begin
                    mem_addr = addr_reg;
                    if (!out_hit) begin
                        mem_req   = 1'b1;
                        mem_we    = is_sw;
                        mem_wdata = b_reg;
                    end
                end
                default: mem_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            res_reg     <= '0;
            addr_reg    <= '0;
            cpu_out_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: if (mem_ready) begin
                    ir_reg <= mem_rdata;
                    pc_reg <= pc_plus4;
                end
                S_DECODE: begin
                    a_reg <= rs_val;
                    b_reg <= rt_val;
                    if (!is_halt && !legal) illegal_reg <= 1'b1;
                    if (!is_halt && is_j)   pc_reg <= j_target;
                end
                S_EXEC: begin
                    res_reg  <= alu_res;
                    addr_reg <= addr_calc;
                    if (is_beq && a_reg == b_reg)      pc_reg <= br_target;
                    if ((is_lw || is_sw) && misaligned) illegal_reg <= 1'b1;
                end
                S_MEM: begin
                    if (out_hit)                 cpu_out_reg <= b_reg;
                    else if (mem_ready && is_lw) res_reg <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

    assign CPU_out = cpu_out_reg;
    assign halted  = (state_reg == S_HALT);
    assign illegal = illegal_reg;
    assign pc_out  = pc_reg;
endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench for mips_multicycle: table of small programs with hand-computed
// results, plus stalled-memory and reset-during-stall sequences.
module tb_mips_multicycle;
    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, pc_out;
    logic [31:0] mem_wdata, CPU_out;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        halted, illegal;

    always #5 clk = ~clk;

    mips_multicycle dut (
        .Clk(clk), .Reset(Reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .CPU_out(CPU_out), .halted(halted),
        .illegal(illegal), .pc_out(pc_out)
    );

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic [31:0] mem   [16384];
    logic [31:0] image [16384];
    bit          stall_en = 0, hold_ready = 0, pulse_ready = 0;
    bit          busy = 0, last_reset = 1;
    int          wait_left = 0;
    int          stab_fails = 0;
    logic [15:0] req_addr = '0;
    bit          req_we = 0;
    logic [31:0] req_wdata = '0;
    int          vectors = 0, miscompares = 0;

    // Memory model: ready/rdata are set on the falling edge for the next rising edge.
    always @(negedge clk) begin
        if (last_reset) busy = 0;
        else if (mem_ready && busy) begin
            if (req_we) mem[req_addr[15:2]] = req_wdata;
            busy = 0;
        end
        mem_ready  = 1'b0;
        last_reset = Reset;
        if (Reset) for (int i = 0; i < 16384; i++) mem[i] = image[i];
        if (pulse_ready) begin
            mem_ready = 1'b1;
            mem_rdata = HALT;
        end else if (mem_req) begin
            if (!busy) begin
                busy      = 1;
                req_addr  = mem_addr;
                req_we    = mem_we;
                req_wdata = mem_wdata;
                wait_left = stall_en ? int'($urandom_range(5, 0)) : 0;
            end else if (mem_addr !== req_addr || mem_we !== req_we || mem_wdata !== req_wdata) begin
                stab_fails++;
            end
            if (!hold_ready && wait_left == 0) begin
                mem_ready = 1'b1;
                mem_rdata = req_we ? 32'h0 : mem[req_addr[15:2]];
            end else if (wait_left > 0) begin
                wait_left--;
            end
        end else if (busy && !Reset) begin
            stab_fails++;
        end
    end

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rr(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sh,
                                       input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] jj(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    function automatic logic [11:0][31:0] pg(
        input logic [31:0] w0 = 0, input logic [31:0] w1 = 0, input logic [31:0] w2 = 0,
        input logic [31:0] w3 = 0, input logic [31:0] w4 = 0, input logic [31:0] w5 = 0,
        input logic [31:0] w6 = 0, input logic [31:0] w7 = 0, input logic [31:0] w8 = 0,
        input logic [31:0] w9 = 0, input logic [31:0] w10 = 0, input logic [31:0] w11 = 0);
        return {w11, w10, w9, w8, w7, w6, w5, w4, w3, w2, w1, w0};
    endfunction

    typedef struct {
        string             name;
        logic [11:0][31:0] prog;
        logic [15:0]       daddr;
        logic [31:0]       dval;
        logic [31:0]       exp_out;
        bit                exp_ill;
        logic [15:0]       exp_pc;
        int                exp_cyc;   // -1: not checked
    } vec_t;

    function automatic vec_t mkv(input string n, input logic [11:0][31:0] p,
                                 input logic [15:0] da, input logic [31:0] dv,
                                 input logic [31:0] eo, input bit ei,
                                 input logic [15:0] ep, input int ec);
        vec_t v;
        v.name = n; v.prog = p; v.daddr = da; v.dval = dv;
        v.exp_out = eo; v.exp_ill = ei; v.exp_pc = ep; v.exp_cyc = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic load_image(input vec_t v);
        for (int i = 0; i < 16384; i++) image[i] = '0;
        for (int k = 0; k < 12; k++) image[k] = v.prog[k];
        if (v.daddr != 16'h0) image[v.daddr[15:2]] = v.dval;
    endtask

    task automatic run_prog(input bit stall, output int cycles, output bit timed_out);
        stall_en    = stall;
        hold_ready  = 0;
        pulse_ready = 0;
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
        end while (!halted && cycles < 3000);
        timed_out = !halted;
    endtask

    vec_t vecs [12];

    initial begin
        int  cyc, n;
        bit  to;
        for (int i = 0; i < 16384; i++) image[i] = '0;

        vecs[0]  = mkv("add_sw", pg(it(6'h08,0,1,16'd5), it(6'h08,0,2,16'd7), rr(1,2,3,0,6'h20),
                        it(6'h2B,0,3,16'hFFEC), HALT), 16'h0, 32'h0, 32'd12, 0, 16'd20, 18);
        vecs[1]  = mkv("beq_loop", pg(it(6'h08,0,1,16'd3), it(6'h08,1,1,16'hFFFF), it(6'h04,1,0,16'h0001),
                        it(6'h04,0,0,16'hFFFD), it(6'h08,1,2,16'h0064), it(6'h2B,0,2,16'hFFEC), HALT),
                        16'h0, 32'h0, 32'h64, 0, 16'd28, 41);
        vecs[2]  = mkv("lw_sw", pg(it(6'h23,0,4,16'h0100), it(6'h2B,0,4,16'hFFEC), HALT),
                        16'h0100, 32'hDEADBEEF, 32'hDEADBEEF, 0, 16'd12, 11);
        vecs[3]  = mkv("r0_write", pg(it(6'h08,0,1,16'd9), rr(1,1,0,0,6'h20), it(6'h08,0,2,16'd1),
                        it(6'h2B,0,2,16'hFFEC), HALT), 16'h0, 32'h0, 32'd1, 0, 16'd20, 18);
        vecs[4]  = mkv("op3f", pg(it(6'h08,0,1,16'd5), it(6'h2B,0,1,16'hFFEC), 32'hFC000000),
                        16'h0, 32'h0, 32'd5, 1, 16'd12, 10);
        vecs[5]  = mkv("lw_misalign", pg(it(6'h08,0,1,16'd7), it(6'h2B,0,1,16'hFFEC), it(6'h23,0,2,16'h0002)),
                        16'h0, 32'h0, 32'd7, 1, 16'd12, 11);
        vecs[6]  = mkv("alu_mix", pg(it(6'h08,0,1,16'hFFFD), it(6'h0D,0,2,16'hF0F0), rr(1,2,3,0,6'h2A),
                        rr(0,2,4,4,6'h00), rr(4,3,5,0,6'h22), rr(5,1,6,0,6'h24), rr(6,2,7,0,6'h25),
                        it(6'h2B,0,7,16'hFFEC), HALT), 16'h0, 32'h0, 32'h000FFEFD, 0, 16'd36, 34);
        vecs[7]  = mkv("jump", pg(jj(26'd3), it(6'h08,0,1,16'd1), HALT, it(6'h08,0,1,16'd2),
                        it(6'h2B,0,1,16'hFFEC), HALT), 16'h0, 32'h0, 32'd2, 0, 16'd24, -1);
        vecs[8]  = mkv("bad_funct", pg(32'h00000021), 16'h0, 32'h0, 32'h0, 1, 16'd4, 2);
        vecs[9]  = mkv("pc_wrap", pg(it(6'h04,5,0,16'h0001), jj(26'd5), jj(26'h3FFF), 32'h0, 32'h0,
                        it(6'h2B,0,5,16'hFFEC), HALT), 16'hFFFC, it(6'h08,0,5,16'h0055),
                        32'h55, 0, 16'd28, -1);
        vecs[10] = mkv("lw_outaddr", pg(it(6'h23,0,4,16'hFFEC), it(6'h2B,0,4,16'hFFEC), HALT),
                        16'hFFEC, 32'h12345678, 32'h12345678, 0, 16'd12, 11);
        vecs[11] = mkv("sw_lw_mem", pg(it(6'h08,0,1,16'h1234), it(6'h2B,0,1,16'h0200), it(6'h23,0,2,16'h0200),
                        it(6'h2B,0,2,16'hFFEC), HALT), 16'h0, 32'h0, 32'h1234, 0, 16'd20, 19);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", 32'(pc_out), 32'h0);
        check("rst_out", CPU_out, 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        $display("reset: pc=%h out=%h halted=%0d req=%0d", pc_out, CPU_out, halted, mem_req);

        for (int i = 0; i < 12; i++) begin
            load_image(vecs[i]);
            run_prog(0, cyc, to);
            check($sformatf("%s_timeout", vecs[i].name), 32'(to), 32'h0);
            check($sformatf("%s_out", vecs[i].name), CPU_out, vecs[i].exp_out);
            check($sformatf("%s_illegal", vecs[i].name), 32'(illegal), 32'(vecs[i].exp_ill));
            check($sformatf("%s_pc", vecs[i].name), 32'(pc_out), 32'(vecs[i].exp_pc));
            if (vecs[i].exp_cyc >= 0)
                check($sformatf("%s_cycles", vecs[i].name), cyc, vecs[i].exp_cyc);
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("%s_halt_hold", vecs[i].name), 32'(halted), 32'h1);
            check($sformatf("%s_req_idle", vecs[i].name), 32'(mem_req), 32'h0);
            $display("vec %0d %s: out=%h illegal=%0d pc=%h cycles=%0d", i, vecs[i].name,
                     CPU_out, illegal, pc_out, cyc);
        end

        // Loop program under random memory stalls
        load_image(vecs[1]);
        run_prog(1, cyc, to);
        check("stall_timeout", 32'(to), 32'h0);
        check("stall_out", CPU_out, 32'h64);
        check("stall_illegal", 32'(illegal), 32'h0);
        check("stall_pc", 32'(pc_out), 32'd28);
        check("stall_stable", stab_fails, 32'h0);
        $display("stall run: out=%h illegal=%0d cycles=%0d", CPU_out, illegal, cyc);

        // Reset while a fetch is stalled, with a ready pulse in the Reset cycle
        load_image(vecs[0]);
        stall_en = 0;
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 Reset = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (CPU_out !== 32'd12 && n < 200);
        check("rststall_reach_out", CPU_out, 32'd12);
        hold_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rststall_req", 32'(mem_req), 32'h1);
        check("rststall_addr", 32'(mem_addr), 32'd16);
        check("rststall_we", 32'(mem_we), 32'h0);
        check("rststall_pc", 32'(pc_out), 32'd16);
        Reset = 1'b1;
        pulse_ready = 1;
        @(posedge clk);
        #1;
        pulse_ready = 0;
        hold_ready = 0;
        check("rststall_pc0", 32'(pc_out), 32'h0);
        check("rststall_out0", CPU_out, 32'h0);
        check("rststall_halted0", 32'(halted), 32'h0);
        check("rststall_req0", 32'(mem_req), 32'h0);
        Reset = 1'b0;
        #1;
        check("rststall_fetch_req", 32'(mem_req), 32'h1);
        check("rststall_fetch_addr", 32'(mem_addr), 32'h0);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!halted && n < 200);
        check("rststall_rerun_out", CPU_out, 32'd12);
        check("rststall_rerun_pc", 32'(pc_out), 32'd20);
        check("rststall_stable", stab_fails, 32'h0);
        $display("reset-in-stall: out=%h pc=%h halted=%0d", CPU_out, pc_out, halted);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
